// File: rtl/mage_pkg.sv
// ============================================================================
//  Module   : mage_pkg
//  Purpose  : Shared constants and types for the MAGE stream datapath:
//             PE-group / bank geometry, crossbar-context sequencer sizing
//             and the sequencer FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial crossbar-context sequencer additions
// ============================================================================
`default_nettype none

package mage_pkg;

  // PE group / memory bank geometry
  localparam int N_PE_PER_GROUP         = 4;
  localparam int N_BANKS_PER_STREAM     = 4;
  localparam int LOG_N_PE_PER_GROUP     = 2;
  localparam int LOG_N_BANKS_PER_STREAM = 2;

  // Crossbar-context sequencer sizing
  localparam int N_XBAR_CTX  = 8;
  localparam int XBAR_ITER_W = 16;

  typedef enum logic [1:0] {
    XSEQ_IDLE = 2'd0,
    XSEQ_RUN  = 2'd1,
    XSEQ_DONE = 2'd2
  } xbar_seq_state_e;

endpackage : mage_pkg

`default_nettype wire

// File: rtl/xbar_sel_sequencer.sv
// ============================================================================
//  Module   : xbar_sel_sequencer
//  Purpose  : Stores N_CTX bank/PE crossbar selector contexts and plays them
//             back in order, n_ctx contexts per iteration for n_iter
//             iterations, driving the crossbar selector inputs directly.
//  Ports    : clk_i, rst_i               clock, synchronous active-high reset
//             cfg_we_i, cfg_addr_i,       context slot write (IDLE only)
//             cfg_sel_dmem_pea_i,
//             cfg_sel_pea_dmem_i
//             n_ctx_i, n_iter_i, start_i  sequence length, start request
//             stall_i                     hold the current context
//             sel_dmem_pea_o,
//             sel_pea_dmem_o              registered crossbar selectors
//             ctx_valid_o, ctx_idx_o      selector valid / context index
//             busy_o, done_o              running flag, completion pulse
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module xbar_sel_sequencer
  import mage_pkg::*;
#(
  parameter  int N_CTX  = N_XBAR_CTX,
  parameter  int CNT_W  = XBAR_ITER_W,
  localparam int IDX_W  = $clog2(N_CTX),
  localparam int NCTX_W = $clog2(N_CTX) + 1
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_i,
  input  logic                                                  cfg_we_i,
  input  logic [IDX_W-1:0]                                      cfg_addr_i,
  input  logic [N_PE_PER_GROUP-1:0][LOG_N_BANKS_PER_STREAM-1:0] cfg_sel_dmem_pea_i,
  input  logic [N_BANKS_PER_STREAM-1:0][LOG_N_PE_PER_GROUP-1:0] cfg_sel_pea_dmem_i,
  input  logic [NCTX_W-1:0]                                     n_ctx_i,
  input  logic [CNT_W-1:0]                                      n_iter_i,
  input  logic                                                  start_i,
  input  logic                                                  stall_i,
  output logic [N_PE_PER_GROUP-1:0][LOG_N_BANKS_PER_STREAM-1:0] sel_dmem_pea_o,
  output logic [N_BANKS_PER_STREAM-1:0][LOG_N_PE_PER_GROUP-1:0] sel_pea_dmem_o,
  output logic                                                  ctx_valid_o,
  output logic [IDX_W-1:0]                                      ctx_idx_o,
  output logic                                                  busy_o,
  output logic                                                  done_o
);

  typedef logic [N_PE_PER_GROUP-1:0][LOG_N_BANKS_PER_STREAM-1:0] sel_dp_t;
  typedef logic [N_BANKS_PER_STREAM-1:0][LOG_N_PE_PER_GROUP-1:0] sel_pd_t;

  xbar_seq_state_e   r_state;
  sel_dp_t           r_slot_dp [N_CTX];
  sel_pd_t           r_slot_pd [N_CTX];
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_iter;
  logic [NCTX_W-1:0] r_n_ctx;
  logic [CNT_W-1:0]  r_n_iter;
  sel_dp_t           r_sel_dp;
  sel_pd_t           r_sel_pd;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  logic              w_last_idx;
  logic              w_last_iter;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [NCTX_W-1:0] w_n_ctx_clamp;

  // Out-of-range context counts are clamped so the index always wraps
  // inside the populated store and the sequence is guaranteed to end.
  assign w_n_ctx_clamp = (n_ctx_i > NCTX_W'(N_CTX)) ? NCTX_W'(N_CTX) : n_ctx_i;
  assign w_last_idx    = ({1'b0, r_idx} == (r_n_ctx - NCTX_W'(1)));
  // Compare against n_iter-1 rather than counting up to n_iter, so the
  // all-ones iteration count never needs a CNT_W+1 bit counter.
  assign w_last_iter   = (r_iter == (r_n_iter - CNT_W'(1)));
  assign w_idx_nxt     = r_idx + IDX_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= XSEQ_IDLE;
      r_idx    <= '0;
      r_iter   <= '0;
      r_n_ctx  <= '0;
      r_n_iter <= '0;
      r_sel_dp <= '0;
      r_sel_pd <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      for (int k = 0; k < N_CTX; k++) begin
        r_slot_dp[k] <= '0;
        r_slot_pd[k] <= '0;
      end
    end else begin
      case (r_state)
        XSEQ_IDLE: begin
          r_done <= 1'b0;
          if (cfg_we_i) begin
            r_slot_dp[cfg_addr_i] <= cfg_sel_dmem_pea_i;
            r_slot_pd[cfg_addr_i] <= cfg_sel_pea_dmem_i;
          end
          if (start_i) begin
            r_n_ctx  <= w_n_ctx_clamp;
            r_n_iter <= n_iter_i;
            r_idx    <= '0;
            r_iter   <= '0;
            if ((w_n_ctx_clamp != '0) && (n_iter_i != '0)) begin
              r_state  <= XSEQ_RUN;
              r_sel_dp <= r_slot_dp[0];
              r_sel_pd <= r_slot_pd[0];
              r_valid  <= 1'b1;
              r_busy   <= 1'b1;
            end else begin
              // Empty sequence: report completion without presenting a context
              r_state <= XSEQ_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        XSEQ_RUN: begin
          if (!stall_i) begin
            if (w_last_idx) begin
              r_idx <= '0;
              if (w_last_iter) begin
                r_state  <= XSEQ_DONE;
                r_iter   <= '0;
                r_sel_dp <= '0;
                r_sel_pd <= '0;
                r_valid  <= 1'b0;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
              end else begin
                r_iter   <= r_iter + CNT_W'(1);
                r_sel_dp <= r_slot_dp[0];
                r_sel_pd <= r_slot_pd[0];
              end
            end else begin
              r_idx    <= w_idx_nxt;
              r_sel_dp <= r_slot_dp[w_idx_nxt];
              r_sel_pd <= r_slot_pd[w_idx_nxt];
            end
          end
        end

        XSEQ_DONE: begin
          r_done  <= 1'b0;
          r_state <= XSEQ_IDLE;
        end

        default: begin
          r_state  <= XSEQ_IDLE;
          r_idx    <= '0;
          r_sel_dp <= '0;
          r_sel_pd <= '0;
          r_valid  <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  // r_idx is held at zero outside RUN, so it doubles as the index output
  assign sel_dmem_pea_o = r_sel_dp;
  assign sel_pea_dmem_o = r_sel_pd;
  assign ctx_valid_o    = r_valid;
  assign ctx_idx_o      = r_idx;
  assign busy_o         = r_busy;
  assign done_o         = r_done;

endmodule : xbar_sel_sequencer

`default_nettype wire

// File: tb/tb_xbar_sel_sequencer.sv
// ============================================================================
//  Module   : tb_xbar_sel_sequencer
//  Purpose  : Directed self-checking bench for xbar_sel_sequencer.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_xbar_sel_sequencer;
  import mage_pkg::*;

  localparam int N_CTX  = N_XBAR_CTX;
  localparam int CNT_W  = XBAR_ITER_W;
  localparam int IDX_W  = $clog2(N_CTX);
  localparam int NCTX_W = IDX_W + 1;
  localparam int DPW    = N_PE_PER_GROUP * LOG_N_BANKS_PER_STREAM;
  localparam int PDW    = N_BANKS_PER_STREAM * LOG_N_PE_PER_GROUP;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              cfg_we_i;
  logic [IDX_W-1:0]  cfg_addr_i;
  logic [DPW-1:0]    cfg_dp;
  logic [PDW-1:0]    cfg_pd;
  logic [NCTX_W-1:0] n_ctx_i;
  logic [CNT_W-1:0]  n_iter_i;
  logic              start_i;
  logic              stall_i;
  logic [N_PE_PER_GROUP-1:0][LOG_N_BANKS_PER_STREAM-1:0] sel_dmem_pea_o;
  logic [N_BANKS_PER_STREAM-1:0][LOG_N_PE_PER_GROUP-1:0] sel_pea_dmem_o;
  logic              ctx_valid_o;
  logic [IDX_W-1:0]  ctx_idx_o;
  logic              busy_o;
  logic              done_o;

  logic [DPW-1:0] exp_dp [N_CTX];
  logic [PDW-1:0] exp_pd [N_CTX];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  xbar_sel_sequencer dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .cfg_we_i           (cfg_we_i),
    .cfg_addr_i         (cfg_addr_i),
    .cfg_sel_dmem_pea_i (cfg_dp),
    .cfg_sel_pea_dmem_i (cfg_pd),
    .n_ctx_i            (n_ctx_i),
    .n_iter_i           (n_iter_i),
    .start_i            (start_i),
    .stall_i            (stall_i),
    .sel_dmem_pea_o     (sel_dmem_pea_o),
    .sel_pea_dmem_o     (sel_pea_dmem_o),
    .ctx_valid_o        (ctx_valid_o),
    .ctx_idx_o          (ctx_idx_o),
    .busy_o             (busy_o),
    .done_o             (done_o)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk_eq({tag, "_valid"}, 32'(ctx_valid_o), 32'd0);
    chk_eq({tag, "_idx"},   32'(ctx_idx_o), 32'd0);
    chk_eq({tag, "_dp"},    32'(sel_dmem_pea_o), 32'd0);
    chk_eq({tag, "_pd"},    32'(sel_pea_dmem_o), 32'd0);
    chk_eq({tag, "_busy"},  32'(busy_o), 32'd0);
  endtask

  task automatic write_slot(input int a, input logic [DPW-1:0] dp, input logic [PDW-1:0] pd);
    cfg_we_i   = 1'b1;
    cfg_addr_i = IDX_W'(a);
    cfg_dp     = dp;
    cfg_pd     = pd;
    tick();
    cfg_we_i   = 1'b0;
    exp_dp[a]  = dp;
    exp_pd[a]  = pd;
  endtask

  // Starts a sequence and follows it cycle by cycle. stall_mask bit c stalls
  // cycle c (cycle 1 is the first cycle after the start edge). wr_in_run
  // attempts a slot-1 overwrite during cycle 1, which must be ignored.
  task automatic run_seq(input int nc, input int ni, input logic [31:0] stall_mask,
                         input bit wr_in_run, input int exp_valid, input int exp_done_cyc);
    int eidx     = 0;
    int eiter    = 0;
    int vcnt     = 0;
    int done_cyc = 0;
    bit efin     = 1'b0;
    n_ctx_i  = NCTX_W'(nc);
    n_iter_i = CNT_W'(ni);
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
    // Latched at start: these new values must not affect the running sequence
    n_ctx_i  = NCTX_W'(1);
    n_iter_i = CNT_W'(7);
    for (int cyc = 1; cyc <= 30 && done_cyc == 0; cyc++) begin
      if (ctx_valid_o) vcnt++;
      if (!efin) begin
        chk_eq("run_valid", 32'(ctx_valid_o), 32'd1);
        chk_eq("run_idx",   32'(ctx_idx_o), 32'(eidx));
        chk_eq("run_dp",    32'(sel_dmem_pea_o), 32'(exp_dp[eidx]));
        chk_eq("run_pd",    32'(sel_pea_dmem_o), 32'(exp_pd[eidx]));
        chk_eq("run_busy",  32'(busy_o), 32'd1);
        chk_eq("run_done",  32'(done_o), 32'd0);
      end else begin
        chk_eq("end_done", 32'(done_o), 32'd1);
        chk_quiet("end");
        done_cyc = cyc;
      end
      stall_i = stall_mask[cyc];
      start_i = (cyc == 2);
      if (wr_in_run && cyc == 1) begin
        cfg_we_i   = 1'b1;
        cfg_addr_i = IDX_W'(1);
        cfg_dp     = 8'h5A;
        cfg_pd     = 8'h96;
      end
      tick();
      stall_i  = 1'b0;
      start_i  = 1'b0;
      cfg_we_i = 1'b0;
      if (!efin && !stall_mask[cyc]) begin
        if (eidx == nc - 1) begin
          eidx = 0;
          if (eiter == ni - 1) efin = 1'b1;
          else eiter++;
        end else begin
          eidx++;
        end
      end
    end
    chk_eq("valid_cycles", 32'(vcnt), 32'(exp_valid));
    chk_eq("done_cycle",   32'(done_cyc), 32'(exp_done_cyc));
    chk_eq("idle_done",    32'(done_o), 32'd0);
  endtask

  task automatic empty_start(input int nc, input int ni);
    n_ctx_i  = NCTX_W'(nc);
    n_iter_i = CNT_W'(ni);
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
    chk_eq("empty_done", 32'(done_o), 32'd1);
    chk_quiet("empty");
    tick();
    chk_eq("empty_done_low", 32'(done_o), 32'd0);
    chk_eq("empty_valid2",   32'(ctx_valid_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i      = 1'b1;
    cfg_we_i   = 1'b0;
    cfg_addr_i = '0;
    cfg_dp     = '0;
    cfg_pd     = '0;
    n_ctx_i    = '0;
    n_iter_i   = '0;
    start_i    = 1'b0;
    stall_i    = 1'b0;
    for (int k = 0; k < N_CTX; k++) begin
      exp_dp[k] = '0;
      exp_pd[k] = '0;
    end
    tick();
    tick();
    chk_quiet("reset");
    chk_eq("reset_done", 32'(done_o), 32'd0);
    rst_i = 1'b0;
    tick();

    write_slot(0, 8'hE4, 8'h39);
    write_slot(1, 8'h1B, 8'hC6);
    write_slot(2, 8'hA7, 8'h72);

    // Basic: 3 contexts x 2 iterations, done on cycle 7
    run_seq(3, 2, 32'h0, 1'b0, 6, 7);
    // Stall on cycles 2 and 3: idx 1 held for 3 cycles
    run_seq(3, 2, 32'h0000_000C, 1'b0, 8, 9);

    // Empty sequences
    empty_start(0, 2);
    empty_start(3, 0);

    // Writes during RUN are ignored, now and for the next run
    run_seq(3, 1, 32'h0, 1'b1, 3, 4);
    run_seq(3, 1, 32'h0, 1'b0, 3, 4);

    // Single-context wrap and full-store wrap (slots 3..7 still zero)
    run_seq(1, 3, 32'h0, 1'b0, 3, 4);
    run_seq(N_CTX, 2, 32'h0, 1'b0, 2 * N_CTX, 2 * N_CTX + 1);

    // Reset mid-run aborts with no done pulse and clears the slots
    n_ctx_i  = NCTX_W'(3);
    n_iter_i = CNT_W'(2);
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
    tick();
    chk_eq("pre_rst_valid", 32'(ctx_valid_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_quiet("abort");
    chk_eq("abort_done", 32'(done_o), 32'd0);
    tick();
    chk_eq("abort_done2", 32'(done_o), 32'd0);
    for (int k = 0; k < N_CTX; k++) begin
      exp_dp[k] = '0;
      exp_pd[k] = '0;
    end
    run_seq(3, 1, 32'h0, 1'b0, 3, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_xbar_sel_sequencer

`default_nettype wire
